// File: rtl/smpc_periph_collector_pkg.sv
// Shared types and constants for the SMPC INTBACK peripheral collector.
`timescale 1ns/1ps
package smpc_periph_collector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_COLLECT,
        ST_PAGE_END,
        ST_PAUSE,
        ST_FINISH
    } coll_state_t;

    localparam logic [7:0] PORT_OFF = 8'hF0;

    // Status bit positions inside the SMPC status register.
    localparam int unsigned SR_PDL = 6;
    localparam int unsigned SR_NPE = 5;
    localparam int unsigned SR_SF  = 0;

    function automatic logic [7:0] sr_status(input logic pdl, input logic npe, input logic sf);
        logic [7:0] sr;
        sr         = '0;
        sr[7]      = 1'b1;
        sr[SR_PDL] = pdl;
        sr[SR_NPE] = npe;
        sr[SR_SF]  = sf;
        return sr;
    endfunction

endpackage

// File: rtl/smpc_periph_collector.sv
// Scans peripheral ports in order and streams their bytes into the OREG window,
// paging with MIRQ_N/CONT/BRK handshakes when the window fills up.
`timescale 1ns/1ps
module smpc_periph_collector
    import smpc_periph_collector_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned OREG_DEPTH = 32,
    parameter int unsigned MAX_PORT_B = 255,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                                 CLK,
    input  logic                                                 RST,
    input  logic                                                 CE,
    input  logic                                                 START,
    input  logic                                                 CONT,
    input  logic                                                 BRK,
    input  logic [NUM_PORTS-1:0]                                 PORT_EN,
    input  logic [7:0]                                           CMD_ECHO,
    output logic                                                 INPUT_ACT,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] INPUT_PORT,
    output logic [7:0]                                           INPUT_POS,
    input  logic [7:0]                                           INPUT_DATA,
    input  logic                                                 INPUT_WE,
    input  logic                                                 INPUT_LAST,
    output logic [$clog2(OREG_DEPTH)-1:0]                        OREG_WA,
    output logic [7:0]                                           OREG_D,
    output logic                                                 OREG_WE,
    output logic                                                 MIRQ_N,
    output logic                                                 SF,
    output logic                                                 PDL,
    output logic                                                 NPE
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned AW = $clog2(OREG_DEPTH);

    localparam logic [AW-1:0] ECHO_SLOT = AW'(OREG_DEPTH - 1);
    localparam logic [AW-1:0] LAST_DATA = AW'(OREG_DEPTH - 2);
    localparam logic [7:0]    POS_MAX   = 8'(MAX_PORT_B - 1);
    localparam logic [15:0]   TMO_MAX   = 16'(TIMEOUT - 1);
    localparam logic [3:0]    PORT_END  = 4'(NUM_PORTS);

    coll_state_t          state;
    logic [NUM_PORTS-1:0] en;
    logic [3:0]           port;
    logic [AW-1:0]        wptr;
    logic [15:0]          tmo;
    logic                 mid;
    logic                 port_on;

    always_comb begin
        port_on = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (port == 4'(i)) port_on = en[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            en         <= '0;
            port       <= '0;
            wptr       <= '0;
            tmo        <= '0;
            mid        <= 1'b0;
            INPUT_ACT  <= 1'b0;
            INPUT_PORT <= '0;
            INPUT_POS  <= '0;
            OREG_WA    <= '0;
            OREG_D     <= '0;
            OREG_WE    <= 1'b0;
            MIRQ_N     <= 1'b1;
            SF         <= 1'b0;
            PDL        <= 1'b0;
            NPE        <= 1'b0;
        end else begin
            OREG_WE <= 1'b0;
            if (CE) begin
                MIRQ_N <= 1'b1;
                case (state)
                    ST_IDLE: begin
                        if (START) begin
                            en    <= PORT_EN;
                            port  <= '0;
                            wptr  <= '0;
                            mid   <= 1'b0;
                            SF    <= 1'b1;
                            PDL   <= 1'b1;
                            NPE   <= 1'b0;
                            state <= ST_SEL;
                        end
                    end
                    // Page-full is detected here for port boundaries so a full window
                    // with ports still pending pages out before the next port starts.
                    ST_SEL: begin
                        if (BRK) begin
                            INPUT_ACT <= 1'b0;
                            SF        <= 1'b0;
                            NPE       <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (port >= PORT_END) begin
                            state <= ST_FINISH;
                        end else if (wptr == ECHO_SLOT) begin
                            mid   <= 1'b0;
                            state <= ST_PAGE_END;
                        end else if (port_on) begin
                            INPUT_ACT  <= 1'b1;
                            INPUT_PORT <= port[PW-1:0];
                            INPUT_POS  <= '0;
                            tmo        <= '0;
                            state      <= ST_COLLECT;
                        end else begin
                            OREG_WE <= 1'b1;
                            OREG_WA <= wptr;
                            OREG_D  <= PORT_OFF;
                            wptr    <= wptr + AW'(1);
                            port    <= port + 4'd1;
                        end
                    end
                    ST_COLLECT: begin
                        if (BRK) begin
                            INPUT_ACT <= 1'b0;
                            SF        <= 1'b0;
                            NPE       <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (INPUT_WE) begin
                            OREG_WE <= 1'b1;
                            OREG_WA <= wptr;
                            OREG_D  <= INPUT_DATA;
                            wptr    <= wptr + AW'(1);
                            tmo     <= '0;
                            if (INPUT_POS != POS_MAX) INPUT_POS <= INPUT_POS + 8'd1;
                            if (INPUT_LAST || INPUT_POS == POS_MAX) begin
                                INPUT_ACT <= 1'b0;
                                port      <= port + 4'd1;
                                state     <= ST_SEL;
                            end else if (wptr == LAST_DATA) begin
                                INPUT_ACT <= 1'b0;
                                mid       <= 1'b1;
                                state     <= ST_PAGE_END;
                            end
                        end else if (tmo == TMO_MAX) begin
                            if (INPUT_POS == 8'd0) begin
                                OREG_WE <= 1'b1;
                                OREG_WA <= wptr;
                                OREG_D  <= PORT_OFF;
                                wptr    <= wptr + AW'(1);
                            end
                            INPUT_ACT <= 1'b0;
                            port      <= port + 4'd1;
                            state     <= ST_SEL;
                        end else begin
                            tmo <= tmo + 16'd1;
                        end
                    end
                    ST_PAGE_END: begin
                        OREG_WE <= 1'b1;
                        OREG_WA <= ECHO_SLOT;
                        OREG_D  <= CMD_ECHO;
                        NPE     <= 1'b1;
                        MIRQ_N  <= 1'b0;
                        state   <= ST_PAUSE;
                    end
                    ST_PAUSE: begin
                        if (BRK) begin
                            SF    <= 1'b0;
                            NPE   <= 1'b0;
                            state <= ST_IDLE;
                        end else if (CONT) begin
                            wptr <= '0;
                            PDL  <= 1'b0;
                            NPE  <= 1'b0;
                            mid  <= 1'b0;
                            if (mid) begin
                                INPUT_ACT <= 1'b1;
                                tmo       <= '0;
                                state     <= ST_COLLECT;
                            end else begin
                                state <= ST_SEL;
                            end
                        end
                    end
                    ST_FINISH: begin
                        OREG_WE <= 1'b1;
                        OREG_WA <= ECHO_SLOT;
                        OREG_D  <= CMD_ECHO;
                        NPE     <= 1'b0;
                        MIRQ_N  <= 1'b0;
                        SF      <= 1'b0;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_smpc_periph_collector.sv
// Randomized bench for smpc_periph_collector: a byte-stream/page model predicts every OREG write and IRQ.
`timescale 1ns/1ps
module tb_smpc_periph_collector;

    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned MAXB  = 255;
    localparam int unsigned TMO   = 1024;
    localparam int unsigned SLOTS = DEPTH - 1;

    logic       clk = 1'b0;
    logic       RST, CE, START, CONT, BRK;
    logic [1:0] PORT_EN;
    logic [7:0] CMD_ECHO;
    logic       INPUT_ACT;
    logic [0:0] INPUT_PORT;
    logic [7:0] INPUT_POS;
    logic [7:0] INPUT_DATA;
    logic       INPUT_WE, INPUT_LAST;
    logic [4:0] OREG_WA;
    logic [7:0] OREG_D;
    logic       OREG_WE, MIRQ_N, SF, PDL, NPE;

    always #5 clk = ~clk;

    smpc_periph_collector #(
        .NUM_PORTS (NP),
        .OREG_DEPTH(DEPTH),
        .MAX_PORT_B(MAXB),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK       (clk),
        .RST       (RST),
        .CE        (CE),
        .START     (START),
        .CONT      (CONT),
        .BRK       (BRK),
        .PORT_EN   (PORT_EN),
        .CMD_ECHO  (CMD_ECHO),
        .INPUT_ACT (INPUT_ACT),
        .INPUT_PORT(INPUT_PORT),
        .INPUT_POS (INPUT_POS),
        .INPUT_DATA(INPUT_DATA),
        .INPUT_WE  (INPUT_WE),
        .INPUT_LAST(INPUT_LAST),
        .OREG_WA   (OREG_WA),
        .OREG_D    (OREG_D),
        .OREG_WE   (OREG_WE),
        .MIRQ_N    (MIRQ_N),
        .SF        (SF),
        .PDL       (PDL),
        .NPE       (NPE)
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Per-case stimulus: what each port's device would deliver.
    logic [7:0]  pdata   [NP][300];
    int unsigned plen    [NP];
    bit          plast   [NP];
    logic [1:0]  en_cfg;
    int unsigned sent    [NP];
    int unsigned act_cyc [NP];
    bit          wr_chk = 1'b0;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_wr[$];

    // Device front-end: answers INPUT_ACT with random gaps, junk WE while inactive.
    always @(negedge clk) begin : front_end
        int p;
        INPUT_WE   = 1'b0;
        INPUT_LAST = 1'b0;
        if (INPUT_ACT === 1'b1) begin
            p = int'(INPUT_PORT);
            act_cyc[p]++;
            expect_eq("act_en", en_cfg[p], 1);
            expect_eq("input_pos", INPUT_POS, sent[p]);
            if (sent[p] < plen[p] && $urandom_range(3) != 0) begin
                INPUT_WE   = 1'b1;
                INPUT_DATA = pdata[p][sent[p]];
                INPUT_LAST = plast[p] && (sent[p] + 1 == plen[p]);
                sent[p]++;
            end
        end else if ($urandom_range(7) == 0) begin
            INPUT_WE   = 1'b1;
            INPUT_DATA = 8'($urandom);
            INPUT_LAST = 1'($urandom_range(1));
        end
    end

    always @(negedge clk) begin : wr_monitor
        wr_t e;
        if (wr_chk && OREG_WE === 1'b1) begin
            if (exp_wr.size() == 0) begin
                expect_eq("wr_extra", OREG_WE, 0);
            end else begin
                e = exp_wr.pop_front();
                expect_eq("wr_addr", OREG_WA, e.a);
                expect_eq("wr_data", OREG_D, e.d);
            end
        end
    end

    task automatic check_reset_vals();
        expect_eq("rst_act", INPUT_ACT, 0);
        expect_eq("rst_we", OREG_WE, 0);
        expect_eq("rst_irq", MIRQ_N, 1);
        expect_eq("rst_sf", SF, 0);
        expect_eq("rst_pdl", PDL, 0);
        expect_eq("rst_npe", NPE, 0);
        expect_eq("rst_wa", OREG_WA, 0);
        expect_eq("rst_pos", INPUT_POS, 0);
        expect_eq("rst_port", INPUT_PORT, 0);
    endtask

    // Model: concatenate every port's contribution into one byte stream, then cut it
    // into pages of SLOTS bytes, each page closed by the echo byte in the top slot.
    task automatic setup_case(input logic [1:0] en, input int unsigned l0, input int unsigned l1,
                              input bit u0, input bit u1, output int unsigned npages);
        logic [7:0]  s[$];
        logic [7:0]  echo;
        int unsigned k, idx;
        wr_t         w;
        en_cfg   = en;
        plen[0]  = l0;
        plen[1]  = l1;
        plast[0] = u0;
        plast[1] = u1;
        for (int p = 0; p < NP; p++) begin
            sent[p]    = 0;
            act_cyc[p] = 0;
            for (int i = 0; i < 300; i++) pdata[p][i] = 8'($urandom);
        end
        echo     = 8'($urandom);
        CMD_ECHO = echo;
        for (int p = 0; p < NP; p++) begin
            if (!en[p] || plen[p] == 0) begin
                s.push_back(8'hF0);
            end else begin
                k = (plen[p] > MAXB) ? MAXB : plen[p];
                for (int unsigned i = 0; i < k; i++) s.push_back(pdata[p][i]);
            end
        end
        npages = (s.size() + SLOTS - 1) / SLOTS;
        exp_wr.delete();
        idx = 0;
        for (int unsigned pg = 0; pg < npages; pg++) begin
            for (int unsigned j = 0; j < SLOTS && idx < s.size(); j++) begin
                w.a = 5'(j);
                w.d = s[idx];
                exp_wr.push_back(w);
                idx++;
            end
            w.a = 5'(SLOTS);
            w.d = echo;
            exp_wr.push_back(w);
        end
    endtask

    task automatic pulse_start(input logic [1:0] en);
        @(negedge clk);
        PORT_EN = en;
        START   = 1'b1;
        @(negedge clk);
        START   = 1'b0;
        PORT_EN = 2'($urandom);
        expect_eq("sf_busy", SF, 1);
    endtask

    task automatic run_case(input logic [1:0] en, input int unsigned l0, input int unsigned l1,
                            input bit u0, input bit u1, input bit abort);
        int unsigned npages;
        bit          last_pg;
        bit          irq_seen;
        int          c;
        setup_case(en, l0, l1, u0, u1, npages);
        if (abort) while (exp_wr.size() > SLOTS + 1) void'(exp_wr.pop_back());
        pulse_start(en);
        for (int unsigned pg = 0; pg < npages; pg++) begin
            c = 0;
            while (MIRQ_N !== 1'b0 && c < 4000) begin
                @(negedge clk);
                c++;
            end
            if (MIRQ_N !== 1'b0) begin
                expect_eq("irq_wait", MIRQ_N, 0);
                return;
            end
            last_pg = (pg == npages - 1);
            expect_eq("irq_pdl", PDL, pg == 0);
            expect_eq("irq_npe", NPE, !last_pg);
            expect_eq("irq_sf", SF, !last_pg);
            @(negedge clk);
            expect_eq("irq_width", MIRQ_N, 1);
            if (last_pg) break;
            repeat ($urandom_range(4)) @(negedge clk);
            START = 1'b1;
            @(negedge clk);
            START = 1'b0;
            expect_eq("pause_npe", NPE, 1);
            if (abort) begin
                CONT = 1'b1;
                BRK  = 1'b1;
                @(negedge clk);
                CONT = 1'b0;
                BRK  = 1'b0;
                expect_eq("brk_sf", SF, 0);
                expect_eq("brk_npe", NPE, 0);
                expect_eq("brk_act", INPUT_ACT, 0);
                irq_seen = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    if (MIRQ_N === 1'b0) irq_seen = 1'b1;
                end
                expect_eq("brk_no_irq", irq_seen, 0);
                expect_eq("brk_wr_left", exp_wr.size(), 0);
                return;
            end
            CONT = 1'b1;
            @(negedge clk);
            CONT = 1'b0;
            expect_eq("cont_pdl", PDL, 0);
            expect_eq("cont_npe", NPE, 0);
        end
        repeat (5) @(negedge clk);
        expect_eq("done_sf", SF, 0);
        expect_eq("done_act", INPUT_ACT, 0);
        expect_eq("done_wr_left", exp_wr.size(), 0);
    endtask

    initial begin
        int unsigned npages;
        RST        = 1'b1;
        CE         = 1'b1;
        START      = 1'b0;
        CONT       = 1'b0;
        BRK        = 1'b0;
        PORT_EN    = '0;
        CMD_ECHO   = '0;
        INPUT_DATA = '0;
        en_cfg     = '0;
        for (int p = 0; p < NP; p++) begin
            plen[p]    = 0;
            plast[p]   = 1'b0;
            sent[p]    = 0;
            act_cyc[p] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals();
        RST    = 1'b0;
        wr_chk = 1'b1;

        run_case(2'b11, 4, 2, 1, 1, 0);
        run_case(2'b01, 3, 5, 1, 1, 0);
        run_case(2'b01, 40, 0, 1, 0, 0);
        run_case(2'b11, 35, 3, 1, 1, 1);
        run_case(2'b11, 0, 3, 0, 1, 0);
        expect_eq("tmo_cycles", act_cyc[0], TMO);
        run_case(2'b11, 5, 4, 0, 1, 0);
        run_case(2'b11, 29, 2, 1, 1, 0);
        run_case(2'b01, 30, 0, 1, 0, 0);
        run_case(2'b01, 31, 0, 1, 0, 0);
        run_case(2'b11, 260, 1, 0, 1, 0);
        run_case(2'b00, 0, 0, 0, 0, 0);

        setup_case(2'b01, 40, 0, 1, 0, npages);
        pulse_start(2'b01);
        repeat (15) @(negedge clk);
        wr_chk = 1'b0;
        RST    = 1'b1;
        @(negedge clk);
        check_reset_vals();
        RST = 1'b0;
        exp_wr.delete();
        wr_chk = 1'b1;
        repeat (10) @(negedge clk);
        run_case(2'b11, 6, 7, 1, 1, 0);

        for (int t = 0; t < 6; t++) begin
            run_case(2'($urandom_range(3)), $urandom_range(1, 70), $urandom_range(1, 70),
                     1'($urandom_range(1)), 1'($urandom_range(1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
